// File: rtl/gpr_wb_arbiter_if.sv
// Write-back bus between the execute/memory requesters, decode and the GPR write port.
// Carries the bypass outputs only when GPR_WB_ARB_BYPASS_EN is defined.
interface gpr_wb_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy_vec;
`ifdef GPR_WB_ARB_BYPASS_EN
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [31:0] fwd_data;
`endif

    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        output iss_valid, iss_rd, q_rs, q_rt,
`ifdef GPR_WB_ARB_BYPASS_EN
        input  fwd_rs_hit, fwd_rt_hit, fwd_data,
`endif
        input  req0_ready, req1_ready, hazard_rs, hazard_rt,
        input  wr_en, wr_addr, wr_data, busy_vec
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        input  iss_valid, iss_rd, q_rs, q_rt,
`ifdef GPR_WB_ARB_BYPASS_EN
        output fwd_rs_hit, fwd_rt_hit, fwd_data,
`endif
        output req0_ready, req1_ready, hazard_rs, hazard_rt,
        output wr_en, wr_addr, wr_data, busy_vec
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Two-requester GPR write-back arbiter with anti-starvation FSM and RAW busy scoreboard.
// Optional same-cycle forwarding of req1 results to decode: GPR_WB_ARB_BYPASS_EN.
module gpr_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    gpr_wb_arbiter_if.slave bus
);
    localparam logic [2:0] MAX_W = 3'(MAX_WAIT);

    typedef enum logic {NORMAL, STARVED} state_t;

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [2:0]  wait_nxt;
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic        xfer0;
    logic        xfer1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // Readys are gated by rst_n so nothing is granted while reset is held.
    assign bus.req0_ready = rst_n && bus.req0_valid && (state == NORMAL  || !bus.req1_valid);
    assign bus.req1_ready = rst_n && bus.req1_valid && (state == STARVED || !bus.req0_valid);
    assign xfer0 = bus.req0_valid && bus.req0_ready;
    assign xfer1 = bus.req1_valid && bus.req1_ready;

    always_comb begin
        wait_nxt = wait_cnt;
        if (!bus.req1_valid || xfer1)
            wait_nxt = '0;
        else if (wait_cnt != MAX_W)
            wait_nxt = wait_cnt + 3'd1;
    end

    // Clear before set so an issue to the register being retired wins.
    always_comb begin
        busy_nxt = busy;
        if (xfer1)
            busy_nxt[bus.req1_rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 5'd0)
            busy_nxt[bus.iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            busy     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            busy     <= busy_nxt;
            case (state)
                NORMAL:  if (wait_nxt == MAX_W) state <= STARVED;
                STARVED: if (xfer1 || !bus.req1_valid) state <= NORMAL;
                default: state <= NORMAL;
            endcase
            wr_en <= 1'b0;
            if (xfer1 && bus.req1_rd != 5'd0) begin
                wr_en   <= 1'b1;
                wr_addr <= bus.req1_rd;
                wr_data <= bus.req1_data;
            end else if (xfer0 && bus.req0_rd != 5'd0) begin
                wr_en   <= 1'b1;
                wr_addr <= bus.req0_rd;
                wr_data <= bus.req0_data;
            end
        end
    end

    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.busy_vec = busy;

`ifdef GPR_WB_ARB_BYPASS_EN
    logic hit_rs;
    logic hit_rt;

    assign hit_rs         = xfer1 && bus.q_rs != 5'd0 && bus.req1_rd == bus.q_rs;
    assign hit_rt         = xfer1 && bus.q_rt != 5'd0 && bus.req1_rd == bus.q_rt;
    assign bus.fwd_rs_hit = hit_rs;
    assign bus.fwd_rt_hit = hit_rt;
    assign bus.fwd_data   = (hit_rs || hit_rt) ? bus.req1_data : 32'd0;
    assign bus.hazard_rs  = busy[bus.q_rs] && !hit_rs;
    assign bus.hazard_rt  = busy[bus.q_rt] && !hit_rt;
`else
    assign bus.hazard_rs  = busy[bus.q_rs];
    assign bus.hazard_rt  = busy[bus.q_rt];
`endif
endmodule
